muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq.sv | 143 ++++++++++++++
 tb/tb_muldiv_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit.
// Uses a 32-cycle shift-add multiplier and a restoring divider that share one 33-bit adder.
module muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        kill,
  output logic        busy,
  output logic        done,
  output logic [31:0] out
);

  // state  | meaning
  // IDLE   | waiting for start; inputs sampled here only
  // CALC   | 32 iterations of shift-add or restoring divide
  // FIX    | sign correction and result select, loads out
  // DONE   | one-cycle done pulse
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [2:0]  op;
  logic [31:0] opnd;
  logic [63:0] acc;
  logic        neg_q;
  logic        neg_r;

  // operand decode at start
  logic        in_mul, s1, s2, n1, n2, div_zero, div_ovf;
  logic [31:0] mag1, mag2;

  always_comb begin
    in_mul   = ~funct3[2];
    s1       = in_mul ? (funct3 != 3'b011) : ~funct3[0];
    s2       = in_mul ? ~funct3[1] : ~funct3[0];
    n1       = s1 & in1[31];
    n2       = s2 & in2[31];
    mag1     = n1 ? (32'd0 - in1) : in1;
    mag2     = n2 ? (32'd0 - in2) : in2;
    div_zero = funct3[2] & (in2 == 32'd0);
    div_ovf  = funct3[2] & ~funct3[0] & (in1 == 32'h8000_0000) & (in2 == 32'hFFFF_FFFF);
  end

  // Shared 33-bit adder: add multiplicand in MUL, subtract divisor in DIV.
  // Partial remainder stays below the divisor, so sum[32] is the borrow.
  logic        is_div;
  logic [32:0] add_a, add_b, sum;
  logic [63:0] step_acc;

  always_comb begin
    is_div = op[2];
    add_a  = is_div ? acc[63:31] : {1'b0, acc[63:32]};
    add_b  = is_div ? ~{1'b0, opnd} : (acc[0] ? {1'b0, opnd} : 33'd0);
    sum    = add_a + add_b + {32'd0, is_div};
    if (is_div)
      step_acc = sum[32] ? {acc[62:0], 1'b0} : {sum[31:0], acc[30:0], 1'b1};
    else
      step_acc = {sum, acc[31:1]};
  end

  logic [63:0] prod;
  logic [31:0] quo, rem, fix_res;

  always_comb begin
    prod = neg_q ? (64'd0 - acc) : acc;
    quo  = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
    rem  = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];
    if (!op[2])
      fix_res = (op[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
    else
      fix_res = op[1] ? rem : quo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 5'd0;
      op    <= 3'd0;
      opnd  <= 32'd0;
      acc   <= 64'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      out   <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !kill) begin
            op  <= funct3;
            cnt <= 5'd31;
            // Special divide cases preload acc so FIX yields the required result.
            if (div_zero) begin
              acc   <= {in1, 32'hFFFF_FFFF};
              opnd  <= mag2;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= S_FIX;
            end else if (div_ovf) begin
              acc   <= {32'd0, 32'h8000_0000};
              opnd  <= mag2;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= S_FIX;
            end else begin
              acc   <= {32'd0, in_mul ? mag2 : mag1};
              opnd  <= in_mul ? mag1 : mag2;
              neg_q <= n1 ^ n2;
              neg_r <= n1;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (kill) begin
            state <= S_IDLE;
          end else begin
            acc <= step_acc;
            cnt <= cnt - 5'd1;
            if (cnt == 5'd0) state <= S_FIX;
          end
        end
        S_FIX: begin
          if (kill) begin
            state <= S_IDLE;
          end else begin
            out   <= fix_res;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq.
// Expected results are hand-computed constants.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [2:0]  funct3;
  logic [31:0] in1, in2;
  logic        busy, done;
  logic [31:0] out;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .in1(in1), .in2(in2), .kill(kill),
    .busy(busy), .done(done), .out(out)
  );

  always #5 clk = ~clk;

  // Drive start for one edge (T) and wait for done. lat is the cycle index
  // relative to T at which done is seen (T+1 is the cycle right after edge T).
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res);
    int cyc;
    @(negedge clk);
    funct3 = f; in1 = a; in2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; lat = -1; res = 32'hDEAD_BEEF;
    while (cyc < 60) begin
      if (done === 1'b1) begin
        lat = cyc; res = out;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL after_done f=%0d: done=%b busy=%b, required 0 0", f, done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'd0; in1 = 32'd0; in2 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b out=%h, required 0 0 00000000", busy, done, out);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  // Vectors: funct3, in1, in2, expected out, expected latency
  task automatic test_ops();
    logic [2:0]  vf [14] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7,
                             3'd4, 3'd6, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] va [14] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                             32'd7, 32'd7, 32'h1234, 32'h1234,
                             32'h8000_0000, 32'h8000_0000};
    logic [31:0] vb [14] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'd2, 32'd2, 32'd7, 32'd7,
                             32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd0, 32'd0,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ve [14] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                             32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                             32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFFF, 32'h1234,
                             32'h8000_0000, 32'd0};
    int          vl [14] = '{34, 34, 34, 34, 34, 34, 34, 34, 34, 34, 2, 2, 2, 2};
    int          lat;
    logic [31:0] res;
    for (int i = 0; i < 14; i++) begin
      run_op(vf[i], va[i], vb[i], lat, res);
      n_tests++;
      if (lat !== vl[i]) begin
        n_fail++;
        $display("FAIL latency op%0d f=%0d: got %0d, required %0d", i, vf[i], lat, vl[i]);
      end
      n_tests++;
      if (res !== ve[i]) begin
        n_fail++;
        $display("FAIL result op%0d f=%0d: got %h, required %h", i, vf[i], res, ve[i]);
      end
    end
  endtask

  task automatic test_kill();
    logic [31:0] prior;
    bit          seen;
    prior = out;
    @(negedge clk);
    funct3 = 3'd0; in1 = 32'd5; in2 = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_busy: busy=%b, required 0", busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen || out !== prior) begin
      n_fail++;
      $display("FAIL kill_nodone: done_seen=%b out=%h, required 0 %h", seen, out, prior);
    end
    // kill in IDLE blocks a start in the same cycle
    @(negedge clk); start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_rst_mid();
    bit          seen;
    int          lat;
    logic [31:0] res;
    @(negedge clk);
    funct3 = 3'd0; in1 = 32'd9; in2 = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (out !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: out=%h busy=%b done=%b, required 00000000 0 0", out, busy, done);
    end
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL rst_nodone: done seen=%b, required 0", seen);
    end
    run_op(3'd0, 32'd12, 32'd11, lat, res);
    n_tests++;
    if (lat !== 34 || res !== 32'd132) begin
      n_fail++;
      $display("FAIL rst_restart: lat=%0d out=%h, required 34 00000084", lat, res);
    end
  endtask

  // start held high through the operation: inputs changed mid-flight must be
  // ignored, and the held start is only taken once IDLE is reached.
  task automatic test_back_to_back();
    int cyc, lat;
    @(negedge clk);
    funct3 = 3'd3; in1 = 32'h0001_0000; in2 = 32'h0003_0000; start = 1'b1;
    @(posedge clk); #1;
    funct3 = 3'd0; in1 = 32'd3; in2 = 32'd4;
    cyc = 1; lat = -1;
    while (cyc < 60) begin
      if (done === 1'b1) begin lat = cyc; break; end
      @(posedge clk); #1;
      cyc++;
    end
    n_tests++;
    if (lat !== 34 || out !== 32'd3) begin
      n_fail++;
      $display("FAIL b2b_first: lat=%0d out=%h, required 34 00000003", lat, out);
    end
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: busy=%b, required 0", busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; lat = -1;
    while (cyc < 60) begin
      if (done === 1'b1) begin lat = cyc; break; end
      @(posedge clk); #1;
      cyc++;
    end
    n_tests++;
    if (lat !== 34 || out !== 32'd12) begin
      n_fail++;
      $display("FAIL b2b_second: lat=%0d out=%h, required 34 0000000c", lat, out);
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_kill();
    test_rst_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
